// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants and helpers for the multi-port register file with busy scoreboard.
package regfile_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 3;
    localparam int unsigned MAX_RD     = 4;
    localparam int unsigned MAX_WR     = 2;

    // Number of registers addressed by an ADDR_W-bit index.
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'(1) << aw;
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback bus into the register file: read lanes, write ports and busy-set.
interface regfile_mp_sb_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 2
) ();

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     busy_set_en;
    logic [ADDR_W-1:0]        busy_set_addr;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, busy_set_en, busy_set_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, busy_set_en, busy_set_addr,
        output rd_data, rd_busy
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One asynchronous read lane: array mux, busy lookup, optional write forwarding
// (enabled by defining REGFILE_BYPASS_EN) and register-0 masking.
module regfile_rd_port #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned ADDR_W  = 3,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned NUM_WR  = 2,
    parameter int unsigned R0_ZERO = 0
) (
    input  logic                     i_rst,
    input  logic [ADDR_W-1:0]        i_rd_addr,
    input  logic [DATA_W-1:0]        i_mem [DEPTH],
    input  logic [DEPTH-1:0]         i_busy,
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    input  logic                     i_busy_set_en,
    input  logic [ADDR_W-1:0]        i_busy_set_addr,
    output logic [DATA_W-1:0]        o_rd_data_c,
    output logic                     o_rd_busy_c
);

`ifndef REGFILE_BYPASS_EN
    // Forwarding inputs are only consumed when the bypass is built in.
    logic w_unused;
    assign w_unused = ^{i_rst, i_wr_en, i_wr_addr, i_wr_data, i_busy_set_en, i_busy_set_addr};
`endif

    // Lane result: stored value, then forwarding (ascending so highest port wins), then r0 mask.
    always_comb begin
        o_rd_data_c = i_mem[i_rd_addr];
        o_rd_busy_c = i_busy[i_rd_addr];
`ifdef REGFILE_BYPASS_EN
        if (!i_rst) begin
            for (int p = 0; p < int'(NUM_WR); p++) begin
                if (i_wr_en[p] && (i_wr_addr[p*ADDR_W +: ADDR_W] == i_rd_addr)) begin
                    o_rd_data_c = i_wr_data[p*DATA_W +: DATA_W];
                    o_rd_busy_c = i_busy_set_en && (i_busy_set_addr == i_rd_addr);
                end
            end
        end
`endif
        if ((R0_ZERO == 1) && (i_rd_addr == '0)) begin
            o_rd_data_c = '0;
            o_rd_busy_c = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register busy scoreboard for RAW detection.
// Optional same-cycle write-to-read forwarding: define REGFILE_BYPASS_EN.
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned NUM_WR  = 2,
    parameter int unsigned R0_ZERO = 0
) (
    input  logic           clk,
    input  logic           rst,
    regfile_mp_sb_if.slave rf
);

    localparam int unsigned DEPTH = depth_of(ADDR_W);

    if ((NUM_RD < 1) || (NUM_RD > MAX_RD) || (NUM_WR < 1) || (NUM_WR > MAX_WR)) begin : g_bad_cfg
        $error("regfile_mp_sb: unsupported port count");
    end

    logic [DATA_W-1:0] r_mem      [DEPTH];
    logic [DATA_W-1:0] w_mem_nxt  [DEPTH];
    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  w_busy_nxt;
    logic [NUM_RD*DATA_W-1:0] w_rd_data;
    logic [NUM_RD-1:0]        w_rd_busy;

    // Next state: writes in ascending port order so the highest index wins; busy set beats clear.
    always_comb begin
        w_mem_nxt  = r_mem;
        w_busy_nxt = r_busy;
        for (int p = 0; p < int'(NUM_WR); p++) begin
            if (rf.wr_en[p]) begin
                if (!((R0_ZERO == 1) && (rf.wr_addr[p*ADDR_W +: ADDR_W] == '0))) begin
                    w_mem_nxt[rf.wr_addr[p*ADDR_W +: ADDR_W]] = rf.wr_data[p*DATA_W +: DATA_W];
                end
                w_busy_nxt[rf.wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (rf.busy_set_en && !((R0_ZERO == 1) && (rf.busy_set_addr == '0))) begin
            w_busy_nxt[rf.busy_set_addr] = 1'b1;
        end
    end

    // Storage and scoreboard; synchronous reset discards same-cycle writes and sets.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= w_mem_nxt[i];
            end
            r_busy <= w_busy_nxt;
        end
    end

    // One combinational read lane per read port.
    for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
        regfile_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .DEPTH   (DEPTH),
            .NUM_WR  (NUM_WR),
            .R0_ZERO (R0_ZERO)
        ) u_rd (
            .i_rst           (rst),
            .i_rd_addr       (rf.rd_addr[k*ADDR_W +: ADDR_W]),
            .i_mem           (r_mem),
            .i_busy          (r_busy),
            .i_wr_en         (rf.wr_en),
            .i_wr_addr       (rf.wr_addr),
            .i_wr_data       (rf.wr_data),
            .i_busy_set_en   (rf.busy_set_en),
            .i_busy_set_addr (rf.busy_set_addr),
            .o_rd_data_c     (w_rd_data[k*DATA_W +: DATA_W]),
            .o_rd_busy_c     (w_rd_busy[k])
        );
    end

    assign rf.rd_data = w_rd_data;
    assign rf.rd_busy = w_rd_busy;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench: default config, R0_ZERO=1 config and a 4-read/1-write 32-bit sweep.
module tb_regfile_mp_sb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_mp_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .NUM_WR(2)) ifa ();
    regfile_mp_sb_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .NUM_WR(2)) ifb ();
    regfile_mp_sb_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4), .NUM_WR(1)) ifc ();

    regfile_mp_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .NUM_WR(2), .R0_ZERO(0))
        dut_a (.clk(clk), .rst(rst), .rf(ifa));
    regfile_mp_sb #(.DATA_W(16), .ADDR_W(3), .NUM_RD(2), .NUM_WR(2), .R0_ZERO(1))
        dut_b (.clk(clk), .rst(rst), .rf(ifb));
    regfile_mp_sb #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4), .NUM_WR(1), .R0_ZERO(0))
        dut_c (.clk(clk), .rst(rst), .rf(ifc));

    typedef struct {
        int          cyc;
        int          dut;
        int          lane;
        logic [31:0] data;
        logic        busy;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    function automatic logic [31:0] act_data(input int dut, input int lane);
        case (dut)
            0:       return 32'(ifa.rd_data[lane*16 +: 16]);
            1:       return 32'(ifb.rd_data[lane*16 +: 16]);
            default: return ifc.rd_data[lane*32 +: 32];
        endcase
    endfunction

    function automatic logic act_busy(input int dut, input int lane);
        case (dut)
            0:       return ifa.rd_busy[lane];
            1:       return ifb.rd_busy[lane];
            default: return ifc.rd_busy[lane];
        endcase
    endfunction

    // Monitor: compare every expectation stamped for the current cycle, mid-cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s stale expectation (cycle %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (act_data(e.dut, e.lane) !== e.data || act_busy(e.dut, e.lane) !== e.busy) begin
                errors++;
                $display("FAIL %s dut%0d lane%0d got data=%h busy=%b expected data=%h busy=%b",
                         e.name, e.dut, e.lane, act_data(e.dut, e.lane), act_busy(e.dut, e.lane),
                         e.data, e.busy);
            end
        end
    end

    task automatic expect_rd(input int dut, input int lane, input logic [31:0] d,
                             input logic b, input string nm);
        exp_t x;
        x.cyc = cyc; x.dut = dut; x.lane = lane; x.data = d; x.busy = b; x.name = nm;
        sb.push_back(x);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ifa.wr_en = '0; ifa.busy_set_en = 1'b0;
        ifb.wr_en = '0; ifb.busy_set_en = 1'b0;
        ifc.wr_en = '0; ifc.busy_set_en = 1'b0;
    endtask

    task automatic wr_a(input int p, input int a, input logic [15:0] d);
        ifa.wr_en[p] = 1'b1;
        ifa.wr_addr[p*3 +: 3] = 3'(a);
        ifa.wr_data[p*16 +: 16] = d;
    endtask

    task automatic rd_a(input int k, input int a);
        ifa.rd_addr[k*3 +: 3] = 3'(a);
    endtask

    initial begin
        ifa.rd_addr = '0; ifa.wr_en = '0; ifa.wr_addr = '0; ifa.wr_data = '0;
        ifa.busy_set_en = 1'b0; ifa.busy_set_addr = '0;
        ifb.rd_addr = '0; ifb.wr_en = '0; ifb.wr_addr = '0; ifb.wr_data = '0;
        ifb.busy_set_en = 1'b0; ifb.busy_set_addr = '0;
        ifc.rd_addr = '0; ifc.wr_en = '0; ifc.wr_addr = '0; ifc.wr_data = '0;
        ifc.busy_set_en = 1'b0; ifc.busy_set_addr = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        rd_a(0, 3); rd_a(1, 7);
        expect_rd(0, 0, 32'h0, 1'b0, "rst_init_r3");
        expect_rd(0, 1, 32'h0, 1'b0, "rst_init_r7");
        wr_a(0, 3, 16'h1234);
        step();
        idle();
        expect_rd(0, 0, 32'h1234, 1'b0, "pre_rst_r3");
        // Reset edge with a write and busy_set pending: both discarded
        rst = 1'b1;
        wr_a(1, 3, 16'h5555);
        ifa.busy_set_en = 1'b1; ifa.busy_set_addr = 3'd3;
        expect_rd(0, 0, 32'h1234, 1'b0, "rst_cycle_r3");
        step();
        rst = 1'b0;
        idle();
        rd_a(1, 3);
        expect_rd(0, 0, 32'h0, 1'b0, "post_rst_r3_l0");
        expect_rd(0, 1, 32'h0, 1'b0, "post_rst_r3_l1");
        step();

        // Basic write/read
        wr_a(0, 5, 16'hBEEF);
        rd_a(0, 5); rd_a(1, 5);
        expect_rd(0, 0, BYP ? 32'hBEEF : 32'h0, 1'b0, "same_cyc_r5");
        step();
        idle();
        expect_rd(0, 0, 32'hBEEF, 1'b0, "rd_r5_l0");
        expect_rd(0, 1, 32'hBEEF, 1'b0, "rd_r5_l1");
        step();

        // Write collision: port 1 wins
        wr_a(0, 2, 16'h1111); wr_a(1, 2, 16'h2222);
        rd_a(0, 2);
        expect_rd(0, 0, BYP ? 32'h2222 : 32'h0, 1'b0, "coll_same_cyc");
        step();
        idle();
        expect_rd(0, 0, 32'h2222, 1'b0, "coll_r2");
        step();

        // Scoreboard set, then clear by writeback
        ifa.busy_set_en = 1'b1; ifa.busy_set_addr = 3'd4;
        rd_a(0, 4);
        expect_rd(0, 0, 32'h0, 1'b0, "busy_set_cyc");
        step();
        idle();
        expect_rd(0, 0, 32'h0, 1'b1, "busy_r4");
        step();
        wr_a(1, 4, 16'h00AA);
        expect_rd(0, 0, BYP ? 32'h00AA : 32'h0, BYP ? 1'b0 : 1'b1, "wb_same_cyc_r4");
        step();
        idle();
        expect_rd(0, 0, 32'h00AA, 1'b0, "wb_clear_r4");
        step();
        // Simultaneous set and write: set wins
        ifa.busy_set_en = 1'b1; ifa.busy_set_addr = 3'd4;
        wr_a(0, 4, 16'h00BB);
        rd_a(1, 5);
        expect_rd(0, 0, BYP ? 32'h00BB : 32'h00AA, BYP ? 1'b1 : 1'b0, "set_wr_same_cyc");
        step();
        idle();
        expect_rd(0, 0, 32'h00BB, 1'b1, "set_beats_clear");
        expect_rd(0, 1, 32'hBEEF, 1'b0, "r5_untouched");
        step();
        // Write to non-busy register leaves busy low; r0 is ordinary here
        wr_a(0, 6, 16'h6666); wr_a(1, 0, 16'hFFFF);
        ifa.busy_set_en = 1'b1; ifa.busy_set_addr = 3'd0;
        step();
        idle();
        rd_a(0, 6); rd_a(1, 0);
        expect_rd(0, 0, 32'h6666, 1'b0, "nonbusy_wr_r6");
        expect_rd(0, 1, 32'hFFFF, 1'b1, "r0_normal");
        step();

        // R0_ZERO=1 instance
        ifb.wr_en = 2'b11;
        ifb.wr_addr = {3'd0, 3'd1};
        ifb.wr_data = {16'hFFFF, 16'h0101};
        ifb.busy_set_en = 1'b1; ifb.busy_set_addr = 3'd0;
        ifb.rd_addr = {3'd1, 3'd0};
        expect_rd(1, 0, 32'h0, 1'b0, "r0z_same_cyc");
        step();
        idle();
        expect_rd(1, 0, 32'h0, 1'b0, "r0z_r0");
        expect_rd(1, 1, 32'h0101, 1'b0, "r0z_r1");
        step();

        // Config sweep: fill 16 registers, read back on all four lanes
        for (int a = 0; a < 16; a++) begin
            ifc.wr_en = 1'b1;
            ifc.wr_addr = 4'(a);
            ifc.wr_data = 32'(a) * 32'h01010101;
            step();
        end
        idle();
        for (int a = 0; a < 16; a++) begin
            for (int k = 0; k < 4; k++) begin
                ifc.rd_addr[k*4 +: 4] = 4'((a + k) % 16);
                expect_rd(2, k, 32'((a + k) % 16) * 32'h01010101, 1'b0, "sweep");
            end
            step();
        end

        step();
        step();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s never compared (cycle %0d)", e.name, e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
